// File: rtl/phy_regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : phy_regfile_mp_if
// Brief    : Issue-read, writeback, rename-alloc and flush bundle of the
//            multi-ported physical register file.
// Revision : 1.0
// ============================================================================
interface phy_regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PHY_WIDTH  = 6,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
);
  logic [NUM_READ-1:0]             rd_valid;
  logic [NUM_READ*PHY_WIDTH-1:0]   rd_rs1_phy;
  logic [NUM_READ*PHY_WIDTH-1:0]   rd_rs2_phy;
  logic [NUM_READ-1:0]             rd_data_valid;
  logic [NUM_READ*DATA_WIDTH-1:0]  rd_rs1_data;
  logic [NUM_READ*DATA_WIDTH-1:0]  rd_rs2_data;
  logic [NUM_READ-1:0]             rd_rs1_ready;
  logic [NUM_READ-1:0]             rd_rs2_ready;
  logic [NUM_WRITE-1:0]            wr_en;
  logic [NUM_WRITE*PHY_WIDTH-1:0]  wr_phy;
  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data;
  logic                            alloc_en;
  logic [PHY_WIDTH-1:0]            alloc_phy;
  logic                            flush;

  modport master (
    output rd_valid, rd_rs1_phy, rd_rs2_phy,
    output wr_en, wr_phy, wr_data, alloc_en, alloc_phy, flush,
    input  rd_data_valid, rd_rs1_data, rd_rs2_data, rd_rs1_ready, rd_rs2_ready
  );

  modport slave (
    input  rd_valid, rd_rs1_phy, rd_rs2_phy,
    input  wr_en, wr_phy, wr_data, alloc_en, alloc_phy, flush,
    output rd_data_valid, rd_rs1_data, rd_rs2_data, rd_rs1_ready, rd_rs2_ready
  );
endinterface
`default_nettype wire

// File: rtl/phy_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : phy_regfile_mp
// Brief    : Multi-ported physical register file with ready bits, write
//            bypass, registered read results and tag 0 hardwired to zero.
// Revision : 1.0
// ============================================================================
module phy_regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int PHY_WIDTH  = 6,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
) (
  input  logic              clk,
  input  logic              rst,
  phy_regfile_mp_if.slave   bus
);
  localparam int c_DEPTH   = 2 ** PHY_WIDTH;
  localparam int c_NUM_SRC = 2 * NUM_READ;

  logic [DATA_WIDTH-1:0]          r_mem [c_DEPTH];
  logic [c_DEPTH-1:0]             r_rdy;
  logic [NUM_READ-1:0]            r_data_valid;
  logic [NUM_READ*DATA_WIDTH-1:0] r_rs1_data;
  logic [NUM_READ*DATA_WIDTH-1:0] r_rs2_data;
  logic [NUM_READ-1:0]            r_rs1_ready;
  logic [NUM_READ-1:0]            r_rs2_ready;

  // Sources 0..NUM_READ-1 are rs1 of each pair, the rest are rs2.
  logic [PHY_WIDTH-1:0]  w_src_tag  [c_NUM_SRC];
  logic [DATA_WIDTH-1:0] w_src_data [c_NUM_SRC];
  logic                  w_src_rdy  [c_NUM_SRC];

  genvar k;
  generate
    for (k = 0; k < c_NUM_SRC; k++) begin : g_src
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_rdy;

      if (k < NUM_READ) begin : g_rs1
        assign w_src_tag[k] = bus.rd_rs1_phy[k*PHY_WIDTH +: PHY_WIDTH];
      end else begin : g_rs2
        assign w_src_tag[k] = bus.rd_rs2_phy[(k-NUM_READ)*PHY_WIDTH +: PHY_WIDTH];
      end

      // Ascending port scan lets the highest-index writer win the bypass;
      // a same-cycle alloc then overrides the bypassed ready.
      always_comb begin
        w_data = r_mem[w_src_tag[k]];
        w_rdy  = r_rdy[w_src_tag[k]];
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (bus.wr_en[j] && (bus.wr_phy[j*PHY_WIDTH +: PHY_WIDTH] == w_src_tag[k])) begin
            w_data = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            w_rdy  = 1'b1;
          end
        end
        if (bus.alloc_en && (bus.alloc_phy == w_src_tag[k])) begin
          w_rdy = 1'b0;
        end
        if (w_src_tag[k] == '0) begin
          w_data = '0;
          w_rdy  = 1'b1;
        end
      end

      assign w_src_data[k] = w_data;
      assign w_src_rdy[k]  = w_rdy;
    end
  endgenerate

  // Storage: later write ports overwrite earlier ones; alloc clears ready last.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < c_DEPTH; e++) begin
        r_mem[e] <= '0;
      end
      r_rdy <= '1;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (bus.wr_en[j] && (bus.wr_phy[j*PHY_WIDTH +: PHY_WIDTH] != '0)) begin
          r_mem[bus.wr_phy[j*PHY_WIDTH +: PHY_WIDTH]] <= bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
          r_rdy[bus.wr_phy[j*PHY_WIDTH +: PHY_WIDTH]] <= 1'b1;
        end
      end
      if (bus.alloc_en && (bus.alloc_phy != '0)) begin
        r_rdy[bus.alloc_phy] <= 1'b0;
      end
    end
  end

  // Read results hold their last value when a pair is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_valid <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_rs1_ready  <= '1;
      r_rs2_ready  <= '1;
    end else begin
      r_data_valid <= bus.rd_valid & ~{NUM_READ{bus.flush}};
      for (int i = 0; i < NUM_READ; i++) begin
        if (bus.rd_valid[i]) begin
          r_rs1_data[i*DATA_WIDTH +: DATA_WIDTH] <= w_src_data[i];
          r_rs2_data[i*DATA_WIDTH +: DATA_WIDTH] <= w_src_data[NUM_READ+i];
          r_rs1_ready[i] <= w_src_rdy[i];
          r_rs2_ready[i] <= w_src_rdy[NUM_READ+i];
        end
      end
    end
  end

  assign bus.rd_data_valid = r_data_valid;
  assign bus.rd_rs1_data   = r_rs1_data;
  assign bus.rd_rs2_data   = r_rs2_data;
  assign bus.rd_rs1_ready  = r_rs1_ready;
  assign bus.rd_rs2_ready  = r_rs2_ready;
endmodule
`default_nettype wire

// File: tb/tb_phy_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_regfile_mp
// Brief    : Directed and random checks of phy_regfile_mp against an
//            array-based reference model.
// Revision : 1.0
// ============================================================================
module tb_phy_regfile_mp;
  localparam int DW    = 32;
  localparam int PW    = 6;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 2 ** PW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phy_regfile_mp_if #(.DATA_WIDTH(DW), .PHY_WIDTH(PW), .NUM_READ(NR), .NUM_WRITE(NW)) bus ();

  phy_regfile_mp #(.DATA_WIDTH(DW), .PHY_WIDTH(PW), .NUM_READ(NR), .NUM_WRITE(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state: register contents, ready bits, expected held outputs.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_rdy [DEPTH];
  logic          exp_valid [NR];
  logic [DW-1:0] exp_d1 [NR];
  logic [DW-1:0] exp_d2 [NR];
  logic          exp_r1 [NR];
  logic          exp_r2 [NR];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value a read of tag sees this cycle: {ready, data}.
  function automatic logic [DW:0] ref_read(input logic [PW-1:0] tag);
    logic [DW-1:0] d;
    logic          r;
    if (tag == '0) return {1'b1, {DW{1'b0}}};
    d = m_mem[tag];
    r = m_rdy[tag];
    for (int j = 0; j < NW; j++)
      if (bus.wr_en[j] && bus.wr_phy[j*PW +: PW] == tag) begin
        d = bus.wr_data[j*DW +: DW];
        r = 1'b1;
      end
    if (bus.alloc_en && bus.alloc_phy == tag) r = 1'b0;
    return {r, d};
  endfunction

  task automatic idle();
    bus.rd_valid   = '0;
    bus.rd_rs1_phy = '0;
    bus.rd_rs2_phy = '0;
    bus.wr_en      = '0;
    bus.wr_phy     = '0;
    bus.wr_data    = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_phy  = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic rd(input int i, input logic [PW-1:0] a, input logic [PW-1:0] b);
    bus.rd_valid[i]            = 1'b1;
    bus.rd_rs1_phy[i*PW +: PW] = a;
    bus.rd_rs2_phy[i*PW +: PW] = b;
  endtask

  task automatic wr(input int j, input logic [PW-1:0] t, input logic [DW-1:0] d);
    bus.wr_en[j]            = 1'b1;
    bus.wr_phy[j*PW +: PW]  = t;
    bus.wr_data[j*DW +: DW] = d;
  endtask

  task automatic alloc(input logic [PW-1:0] t);
    bus.alloc_en  = 1'b1;
    bus.alloc_phy = t;
  endtask

  // Predict from current inputs, advance the model, clock, then compare.
  task automatic cycle();
    logic [DW:0] r;
    for (int i = 0; i < NR; i++) begin
      if (rst) begin
        exp_valid[i] = 1'b0;
        exp_d1[i] = '0; exp_d2[i] = '0;
        exp_r1[i] = 1'b1; exp_r2[i] = 1'b1;
      end else begin
        exp_valid[i] = bus.rd_valid[i] && !bus.flush;
        if (bus.rd_valid[i]) begin
          r = ref_read(bus.rd_rs1_phy[i*PW +: PW]);
          exp_d1[i] = r[DW-1:0]; exp_r1[i] = r[DW];
          r = ref_read(bus.rd_rs2_phy[i*PW +: PW]);
          exp_d2[i] = r[DW-1:0]; exp_r2[i] = r[DW];
        end
      end
    end
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        m_mem[e] = '0;
        m_rdy[e] = 1'b1;
      end
    end else begin
      for (int j = 0; j < NW; j++)
        if (bus.wr_en[j] && bus.wr_phy[j*PW +: PW] != '0) begin
          m_mem[bus.wr_phy[j*PW +: PW]] = bus.wr_data[j*DW +: DW];
          m_rdy[bus.wr_phy[j*PW +: PW]] = 1'b1;
        end
      if (bus.alloc_en && bus.alloc_phy != '0) m_rdy[bus.alloc_phy] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("valid[%0d]", i),     bus.rd_data_valid[i],            exp_valid[i]);
      chk($sformatf("rs1_data[%0d]", i),  bus.rd_rs1_data[i*DW +: DW],     exp_d1[i]);
      chk($sformatf("rs2_data[%0d]", i),  bus.rd_rs2_data[i*DW +: DW],     exp_d2[i]);
      chk($sformatf("rs1_ready[%0d]", i), bus.rd_rs1_ready[i],             exp_r1[i]);
      chk($sformatf("rs2_ready[%0d]", i), bus.rd_rs2_ready[i],             exp_r2[i]);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // Basic read of a written tag alongside tag 0
    idle(); wr(0, 6'd5, 32'hDEAD_BEEF); cycle();
    idle(); rd(0, 6'd5, 6'd0);          cycle();
    chk("basic_rs1", bus.rd_rs1_data[0 +: DW], 32'hDEAD_BEEF);

    // Two writers on one tag with a same-cycle read: port 1 wins
    idle(); wr(0, 6'd9, 32'h11); wr(1, 6'd9, 32'h22); rd(0, 6'd9, 6'd0); cycle();
    chk("bypass_prio", bus.rd_rs1_data[0 +: DW], 32'h22);
    idle(); rd(1, 6'd9, 6'd9); cycle();
    chk("array_prio", bus.rd_rs2_data[DW +: DW], 32'h22);

    // Ready tracking through alloc and writeback
    idle(); alloc(6'd12);                  cycle();
    idle(); rd(0, 6'd12, 6'd12);           cycle();
    idle(); wr(1, 6'd12, 32'h7);           cycle();
    idle(); rd(0, 6'd12, 6'd0);            cycle();
    idle(); alloc(6'd12); wr(0, 6'd12, 32'h55); rd(1, 6'd12, 6'd12); cycle();
    idle(); rd(0, 6'd12, 6'd12);           cycle();
    chk("alloc_wins_ready", bus.rd_rs1_ready[0], 1'b0);

    // Tag 0 ignores writes and allocs
    idle(); wr(0, 6'd0, 32'hFFFF_FFFF); alloc(6'd0); rd(0, 6'd0, 6'd0); cycle();
    idle(); rd(1, 6'd0, 6'd0); cycle();

    // Flush kills the result but not the concurrent write
    idle(); rd(1, 6'd3, 6'd3); wr(0, 6'd3, 32'h33); bus.flush = 1'b1; cycle();
    idle(); rd(1, 6'd3, 6'd0); cycle();
    chk("flush_write", bus.rd_rs1_data[DW +: DW], 32'h33);

    // Reset in the middle of activity
    idle(); wr(0, 6'd4, 32'h44); wr(1, 6'd7, 32'h77); cycle();
    idle(); alloc(6'd8); cycle();
    idle(); rd(0, 6'd4, 6'd7); rd(1, 6'd8, 6'd8); rst = 1'b1; cycle();
    rst = 1'b0;
    idle(); rd(0, 6'd4, 6'd7); rd(1, 6'd8, 6'd8); cycle();
    idle(); cycle();

    // Random traffic concentrated on few tags for frequent collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 1) == 1)
          rd(i, 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)));
      for (int j = 0; j < NW; j++)
        if ($urandom_range(0, 1) == 1)
          wr(j, 6'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 2) == 0) alloc(6'($urandom_range(0, 15)));
      bus.flush = ($urandom_range(0, 7) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/phy_regfile_mp.md
PHY_REGFILE_MP -- requirements
Module: phy_regfile_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter PHY_WIDTH, default 6, physical tag width; 2**PHY_WIDTH entries.
REQ-003 SHALL have parameter NUM_READ, default 2, number of issue read pairs (rs1+rs2 each).
REQ-004 SHALL have parameter NUM_WRITE, default 2, number of writeback ports.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset; single clock domain, rst synchronous active-high.
REQ-006 SHALL have ports: rd_valid in NUM_READ, per-pair read request; rd_rs1_phy in NUM_READ*PHY_WIDTH, rd_rs2_phy in NUM_READ*PHY_WIDTH, source tags (pair i at bits [i*PHY_WIDTH +: PHY_WIDTH]).
REQ-007 SHALL have ports: rd_data_valid out NUM_READ; rd_rs1_data out NUM_READ*DATA_WIDTH; rd_rs2_data out NUM_READ*DATA_WIDTH; rd_rs1_ready out NUM_READ; rd_rs2_ready out NUM_READ (operand-ready flags).
REQ-008 SHALL have ports: wr_en in NUM_WRITE; wr_phy in NUM_WRITE*PHY_WIDTH; wr_data in NUM_WRITE*DATA_WIDTH; writeback ports.
REQ-009 SHALL have ports: alloc_en in 1; alloc_phy in PHY_WIDTH; marks a tag busy at rename.
REQ-010 SHALL have port flush in 1; cancels in-flight read results.

Function
REQ-011 SHALL hold a data array of 2**PHY_WIDTH x DATA_WIDTH and a ready-bit vector of 2**PHY_WIDTH.
REQ-012 SHALL treat tag 0 as hardwired: reads return 0, ready=1; writes and allocs to tag 0 ignored.
REQ-013 SHALL register read results: request at cycle N -> rd_data_valid[i]=1 with data/ready at cycle N+1; rd_data_valid[i]=0 at N+1 when rd_valid[i]=0 at N.
REQ-014 SHALL hold rd_*_data and rd_*_ready unchanged when rd_valid[i]=0 (only rd_data_valid drops).
REQ-015 SHALL bypass: if wr_en[j] at cycle N matches a read tag at cycle N, the registered result at N+1 carries wr_data[j] and ready=1.
REQ-016 SHALL resolve multiple write ports hitting the same tag in one cycle by highest port index winning, for both array and bypass.
REQ-017 SHALL set ready bit of wr_phy[j] to 1 at the next edge for each wr_en[j].
REQ-018 SHALL clear ready bit of alloc_phy at the next edge when alloc_en=1; alloc has priority over write for the ready bit when same tag, data still written.
REQ-019 SHALL report alloc in the same cycle as a read of that tag as ready=0 at N+1 (alloc dominates bypass ready; data bypass still applies).
REQ-020 SHALL, on flush at cycle N, force rd_data_valid to 0 at N+1 regardless of rd_valid at N; array and ready bits unaffected, writes at N still performed.
REQ-021 SHALL serve all NUM_READ pairs and NUM_WRITE ports independently every cycle; no stall, no backpressure.
REQ-022 SHALL treat identical rs1/rs2 tags within or across pairs as independent reads returning identical values.

Reset
REQ-023 SHALL, on rst sampled high, clear all data entries to 0, set all ready bits to 1, drive rd_data_valid, rd_*_data to 0 and rd_*_ready to 1 at the following cycle.
REQ-024 SHALL give rst priority over wr_en, alloc_en, flush and rd_valid in the same cycle; a read in the reset cycle yields no valid result.
REQ-025 SHALL resume normal operation the first cycle after rst deasserts.

Verification
REQ-026 Basic read: write tag 5=0xDEADBEEF, next cycle rd_valid[0]=1 rs1=5 rs2=0 -> N+1 rs1_data=0xDEADBEEF, rs2_data=0, both ready=1, rd_data_valid[0]=1.
REQ-027 Bypass + port priority: same cycle wr_en[0] tag 9=0x11, wr_en[1] tag 9=0x22, read rs1=9 -> N+1 rs1_data=0x22 ready=1; later read of 9 returns 0x22.
REQ-028 Ready tracking: alloc_en tag 12, next cycle read 12 -> ready=0; write 12=0x7 then read -> ready=1 data=0x7; alloc+write 12 same cycle -> subsequent read ready=0, data new value.
REQ-029 Tag 0: write 0=0xFFFF_FFFF, alloc 0, read 0 -> data 0, ready 1.
REQ-030 Flush: rd_valid[1]=1 with flush=1 -> N+1 rd_data_valid[1]=0; concurrent write to tag 3 visible on next read.
REQ-031 Reset mid-operation: write tags 4,7, alloc 8, assert rst one cycle with rd_valid=1 -> next cycle rd_data_valid=0; reads of 4,7,8 return 0 with ready=1.
